// File: rtl/aximm_rd_burst_chk.sv
// aximm_rd_burst_chk: AXI4 read burst generator and checker.
// Issues one INCR read burst per start pulse. Each returning beat is compared
// against an incrementing 32-bit word pattern (seed + k*NW + j). The first and
// last beats are captured, and sticky response/RLAST error flags are kept.
// Optional watchdog: define AXIMM_RD_CHK_TIMEOUT_EN to build it in. Without it,
// o_timeout is tied low and the block waits indefinitely for the slave.

// Per-word pattern comparator; one instance per 32-bit word of the R bus.
module aximm_rd_burst_chk_lane (
  input  logic [31:0] i_word,
  input  logic [31:0] i_exp,
  output logic        o_mis
);
  assign o_mis = (i_word != i_exp);
endmodule

module aximm_rd_burst_chk #(
  parameter int DATA_WIDTH     = 128,
  parameter int ADDR_WIDTH     = 32,
  parameter int ID_WIDTH       = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                  ms_rd_clk,
  input  logic                  i_m_rd_rst_n,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [7:0]            i_len,
  input  logic [31:0]           i_seed,
  output logic [ADDR_WIDTH-1:0] o_araddr,
  output logic [7:0]            o_arlen,
  output logic [2:0]            o_arsize,
  output logic [1:0]            o_arburst,
  output logic [ID_WIDTH-1:0]   o_arid,
  output logic                  o_arvalid,
  input  logic                  i_arready,
  input  logic [DATA_WIDTH-1:0] i_rdata,
  input  logic [1:0]            i_rresp,
  input  logic                  i_rlast,
  input  logic [ID_WIDTH-1:0]   i_rid,
  input  logic                  i_rvalid,
  output logic                  o_rready,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_pass,
  output logic [15:0]           o_err_cnt,
  output logic                  o_resp_err,
  output logic                  o_rlast_err,
  output logic                  o_timeout,
  output logic [DATA_WIDTH-1:0] o_first_data,
  output logic [DATA_WIDTH-1:0] o_last_data
);
  localparam int NW = DATA_WIDTH / 32;
  localparam logic [2:0] AR_SIZE = 3'($clog2(DATA_WIDTH / 8));

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_DONE} state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_araddr;
  logic [7:0]            r_len;
  logic [31:0]           r_base;     // pattern value of word 0 of the current beat
  logic [8:0]            r_beat;
  logic                  r_arvalid;
  logic                  r_rready;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_pass;
  logic [15:0]           r_err_cnt;
  logic                  r_resp_err;
  logic                  r_rlast_err;
  logic [DATA_WIDTH-1:0] r_first;
  logic [DATA_WIDTH-1:0] r_last;

  logic [NW-1:0][31:0]   w_exp;
  logic [NW-1:0]         w_mis;
  logic                  w_beat;
  logic                  w_final;
  logic                  w_end;
  logic                  w_start_acc;
  logic [15:0]           w_err_cnt_nxt;
  logic                  w_resp_err_nxt;
  logic                  w_rlast_err_nxt;
  logic                  w_timeout;
  logic                  w_wd_fire;

  // Per-word expected value and compare.
  for (genvar gi = 0; gi < NW; gi++) begin : g_lane
    assign w_exp[gi] = r_base + 32'(gi);
    aximm_rd_burst_chk_lane u_lane (
      .i_word (i_rdata[gi*32 +: 32]),
      .i_exp  (w_exp[gi]),
      .o_mis  (w_mis[gi])
    );
  end

  // rready is only ever high in DATA, so this is the accepted-beat strobe.
  assign w_beat      = r_rready & i_rvalid;
  assign w_final     = (r_beat == {1'b0, r_len});
  assign w_end       = i_rlast | w_final;
  assign w_start_acc = i_start & ((r_state == S_IDLE) | (r_state == S_DONE));

  // Post-beat status, so pass can include the final beat's own errors.
  assign w_err_cnt_nxt   = (w_beat && (|w_mis) && (r_err_cnt != 16'hFFFF))
                           ? r_err_cnt + 16'd1 : r_err_cnt;
  assign w_resp_err_nxt  = r_resp_err  | (w_beat & ((i_rresp != 2'b00) | (i_rid != '0)));
  assign w_rlast_err_nxt = r_rlast_err | (w_beat & (i_rlast ^ w_final));

`ifdef AXIMM_RD_CHK_TIMEOUT_EN
  logic [15:0] r_wdog;
  logic        r_timeout;
  logic        w_hs;
  logic        w_active;

  assign w_hs      = (r_arvalid & i_arready) | w_beat;
  assign w_active  = (r_state == S_ADDR) | (r_state == S_DATA);
  assign w_wd_fire = w_active & ~w_hs & (r_wdog == 16'(TIMEOUT_CYCLES - 1));
  assign w_timeout = r_timeout;

  // Watchdog: counts stalled cycles while a burst is in flight.
  always_ff @(posedge ms_rd_clk or negedge i_m_rd_rst_n) begin
    if (!i_m_rd_rst_n) begin
      r_wdog    <= '0;
      r_timeout <= 1'b0;
    end else begin
      if (w_start_acc) r_timeout <= 1'b0;
      else if (w_wd_fire) r_timeout <= 1'b1;
      if (!w_active || w_hs || w_wd_fire) r_wdog <= '0;
      else r_wdog <= r_wdog + 16'd1;
    end
  end
`else
  logic w_unused_to;
  assign w_unused_to = |32'(TIMEOUT_CYCLES);
  assign w_wd_fire   = 1'b0;
  assign w_timeout   = 1'b0;
`endif

  // Burst FSM: AR issue, R accept/check/capture, status update.
  always_ff @(posedge ms_rd_clk or negedge i_m_rd_rst_n) begin
    if (!i_m_rd_rst_n) begin
      r_state     <= S_IDLE;
      r_araddr    <= '0;
      r_len       <= '0;
      r_base      <= '0;
      r_beat      <= '0;
      r_arvalid   <= 1'b0;
      r_rready    <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_err_cnt   <= '0;
      r_resp_err  <= 1'b0;
      r_rlast_err <= 1'b0;
      r_first     <= '0;
      r_last      <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (i_start) begin
            r_araddr    <= i_addr;
            r_len       <= i_len;
            r_base      <= i_seed;
            r_beat      <= '0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_err_cnt   <= '0;
            r_resp_err  <= 1'b0;
            r_rlast_err <= 1'b0;
            r_first     <= '0;
            r_last      <= '0;
            r_arvalid   <= 1'b1;
            r_busy      <= 1'b1;
            r_state     <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (w_wd_fire) begin
            r_arvalid <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_pass    <= 1'b0;
            r_state   <= S_DONE;
          end else if (i_arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= S_DATA;
          end
        end
        S_DATA: begin
          if (w_beat) begin
            r_beat      <= r_beat + 9'd1;
            r_base      <= r_base + 32'(NW);
            r_err_cnt   <= w_err_cnt_nxt;
            r_resp_err  <= w_resp_err_nxt;
            r_rlast_err <= w_rlast_err_nxt;
            r_last      <= i_rdata;
            if (r_beat == 9'd0) r_first <= i_rdata;
            if (w_end) begin
              r_rready <= 1'b0;
              r_busy   <= 1'b0;
              r_done   <= 1'b1;
              r_pass   <= (w_err_cnt_nxt == 16'd0) & ~w_resp_err_nxt &
                          ~w_rlast_err_nxt & ~w_timeout;
              r_state  <= S_DONE;
            end
          end else if (w_wd_fire) begin
            r_rready <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
            r_pass   <= 1'b0;
            r_state  <= S_DONE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_araddr     = r_araddr;
  assign o_arlen      = r_len;
  assign o_arsize     = AR_SIZE;
  assign o_arburst    = 2'b01;
  assign o_arid       = '0;
  assign o_arvalid    = r_arvalid;
  assign o_rready     = r_rready;
  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_pass       = r_pass;
  assign o_err_cnt    = r_err_cnt;
  assign o_resp_err   = r_resp_err;
  assign o_rlast_err  = r_rlast_err;
  assign o_timeout    = w_timeout;
  assign o_first_data = r_first;
  assign o_last_data  = r_last;
endmodule

// File: tb/tb_aximm_rd_burst_chk.sv
// Bench for aximm_rd_burst_chk: directed test-plan bursts plus randomized
// bursts, checked against a pattern model computed from the sent beats.
module tb_aximm_rd_burst_chk;
  localparam int DW = 128;
  localparam int AW = 32;
  localparam int IW = 4;
  localparam int NW = DW / 32;
  localparam int TO = 64;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [7:0]    len = '0;
  logic [31:0]   seed = '0;
  logic [AW-1:0] araddr;
  logic [7:0]    arlen;
  logic [2:0]    arsize;
  logic [1:0]    arburst;
  logic [IW-1:0] arid;
  logic          arvalid;
  logic          arready = 1'b0;
  logic [DW-1:0] rdata = '0;
  logic [1:0]    rresp = '0;
  logic          rlast = 1'b0;
  logic [IW-1:0] rid = '0;
  logic          rvalid = 1'b0;
  logic          rready;
  logic          busy, done, pass, resp_err, rlast_err, timeout;
  logic [15:0]   err_cnt;
  logic [DW-1:0] first_data, last_data;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  aximm_rd_burst_chk #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW),
                       .TIMEOUT_CYCLES(TO)) dut (
    .ms_rd_clk(clk), .i_m_rd_rst_n(rst_n), .i_start(start), .i_addr(addr),
    .i_len(len), .i_seed(seed), .o_araddr(araddr), .o_arlen(arlen),
    .o_arsize(arsize), .o_arburst(arburst), .o_arid(arid), .o_arvalid(arvalid),
    .i_arready(arready), .i_rdata(rdata), .i_rresp(rresp), .i_rlast(rlast),
    .i_rid(rid), .i_rvalid(rvalid), .o_rready(rready), .o_busy(busy),
    .o_done(done), .o_pass(pass), .o_err_cnt(err_cnt), .o_resp_err(resp_err),
    .o_rlast_err(rlast_err), .o_timeout(timeout), .o_first_data(first_data),
    .o_last_data(last_data)
  );

  task automatic chk(string tag, logic [DW-1:0] act, logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Reference beat: word j of beat k is seed + k*NW + j (mod 2^32).
  function automatic logic [DW-1:0] pat(logic [31:0] s, int k);
    logic [DW-1:0] d;
    for (int j = 0; j < NW; j++) d[j*32 +: 32] = s + 32'(k*NW + j);
    return d;
  endfunction

  task automatic chk_all_zero(string nm);
    chk({nm, ".ctl"}, {busy, arvalid, rready, done, pass, resp_err, rlast_err, timeout}, '0);
    chk({nm, ".err_cnt"}, err_cnt, '0);
    chk({nm, ".first"}, first_data, '0);
    chk({nm, ".last"}, last_data, '0);
  endtask

  // One burst as seen from a scripted slave. Negative indices disable a feature.
  task automatic run_burst(string nm, logic [31:0] a, logic [7:0] l, logic [31:0] s,
                           int ar_dly, bit gaps, int bad_beat, int bad_bit,
                           int early_beat, bit withhold, int resp_beat,
                           int rst_beat, int mid_start_beat, int stop_after);
    logic [DW-1:0] sent[$];
    bit            slast[$];
    bit            sresp[$];
    logic [DW-1:0] d;
    bit            ok, hs, bl, stable;
    int            nsend, exp_err, n;
    bit            exp_resp, exp_rl;

    addr = a; len = l; seed = s; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({nm, ".arvalid"}, arvalid, 1'b1);
    chk({nm, ".ar_payload"}, {araddr, arlen, arsize, arburst, arid},
        {a, l, 3'd4, 2'b01, 4'd0});
    chk({nm, ".busy_done"}, {busy, done}, 2'b10);

    stable = 1'b1;
    for (int i = 0; i < ar_dly; i++) begin
      @(posedge clk); #1;
      if (arvalid !== 1'b1 || araddr !== a || arlen !== l) stable = 1'b0;
    end
    if (ar_dly > 0) chk({nm, ".ar_stable"}, stable, 1'b1);

    arready = 1'b1;
    @(posedge clk); #1;
    arready = 1'b0;
    chk({nm, ".rready_up"}, {arvalid, rready}, 2'b01);

    nsend = (early_beat >= 0) ? early_beat + 1 : int'(l) + 1;
    for (int k = 0; k < nsend; k++) begin
      if (stop_after >= 0 && k == stop_after) break;
      if (gaps && $urandom_range(0, 2) == 0) begin
        n = $urandom_range(1, 3);
        repeat (n) begin @(posedge clk); #1; end
      end
      d = pat(s, k);
      if (k == bad_beat) d[bad_bit] = ~d[bad_bit];
      bl = (early_beat >= 0) ? (k == early_beat) : (!withhold && k == int'(l));
      rdata = d; rvalid = 1'b1; rlast = bl;
      rresp = (k == resp_beat) ? 2'b10 : 2'b00;
      if (k == mid_start_beat) begin addr = ~a; start = 1'b1; end
      ok = 1'b0;
      for (int t = 0; t < 64 && !ok; t++) begin
        hs = rready;
        @(posedge clk); #1;
        ok = hs;
      end
      start = 1'b0; rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
      if (!ok) begin
        chk({nm, ".r_handshake"}, ok, 1'b1);
        return;
      end
      sent.push_back(d); slast.push_back(bl); sresp.push_back(k == resp_beat);
      if (k == mid_start_beat) chk({nm, ".mid_start_ignored"}, arvalid, 1'b0);
      if (k + 1 < nsend && (k == 0 || k == mid_start_beat))
        chk({nm, ".in_flight"}, {busy, done}, 2'b10);
      if (rst_beat >= 0 && k + 1 == rst_beat) begin
        rst_n = 1'b0; #1;
        chk_all_zero({nm, ".rst"});
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        return;
      end
    end

    if (stop_after >= 0) begin
      n = 0;
      while (!done && n < 200) begin @(posedge clk); #1; n++; end
      chk({nm, ".wdog_cycles"}, n, TO);
      chk({nm, ".wdog_flags"}, {timeout, done, pass, busy, rready}, 5'b11000);
      return;
    end

    // Model: accepted beats vs pattern and the RLAST rule.
    exp_err = 0; exp_resp = 1'b0; exp_rl = 1'b0;
    for (int i = 0; i < sent.size(); i++) begin
      if (sent[i] != pat(s, i)) exp_err++;
      if (sresp[i]) exp_resp = 1'b1;
      if (slast[i] != (i == int'(l))) exp_rl = 1'b1;
    end
    chk({nm, ".done"}, {done, busy, rready}, 3'b100);
    chk({nm, ".err_cnt"}, err_cnt, 16'(exp_err));
    chk({nm, ".flags"}, {resp_err, rlast_err, timeout}, {exp_resp, exp_rl, 1'b0});
    chk({nm, ".pass"}, pass, (exp_err == 0) && !exp_resp && !exp_rl);
    chk({nm, ".first"}, first_data, sent[0]);
    chk({nm, ".last"}, last_data, sent[sent.size()-1]);
    @(posedge clk); #1;
    chk({nm, ".done_sticky"}, done, 1'b1);
  endtask

  initial begin
    logic [7:0] rl;
    int         bb;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_burst("clean128", 32'h1000_0000, 8'd127, 32'd0, 0, 1'b0, -1, 0, -1, 1'b0, -1, -1, -1, -1);
    chk("clean128.first_lit", first_data, 128'h00000003_00000002_00000001_00000000);
    chk("clean128.last_lit", last_data, 128'h000001FF_000001FE_000001FD_000001FC);

    run_burst("flip", 32'h1000_0000, 8'd127, 32'd0, 0, 1'b0, 5, 64, -1, 1'b0, -1, -1, -1, -1);
    chk("flip.err_lit", {err_cnt, pass}, {16'd1, 1'b0});

    run_burst("early", 32'h0000_4000, 8'd15, 32'hA5A5_0000, 0, 1'b0, -1, 0, 9, 1'b0, -1, -1, -1, -1);
    chk("early.rlast_lit", rlast_err, 1'b1);
    run_burst("withhold", 32'h0000_4000, 8'd15, 32'h0000_0100, 0, 1'b0, -1, 0, -1, 1'b1, -1, -1, -1, -1);
    chk("withhold.rlast_lit", rlast_err, 1'b1);

    run_burst("rresp", 32'h0000_8000, 8'd7, 32'h0000_0040, 0, 1'b0, -1, 0, -1, 1'b0, 3, -1, -1, -1);
    chk("rresp.lit", {resp_err, pass, err_cnt}, {1'b1, 1'b0, 16'd0});

    run_burst("ardly", 32'h0001_0000, 8'd31, 32'hFFFF_FFF8, 7, 1'b1, -1, 0, -1, 1'b0, -1, -1, -1, -1);
    chk("ardly.pass_lit", pass, 1'b1);

    run_burst("rst40", 32'h1000_0000, 8'd127, 32'd0, 0, 1'b0, -1, 0, -1, 1'b0, -1, 40, -1, -1);
    run_burst("post_rst", 32'h1000_0000, 8'd127, 32'd0, 0, 1'b0, -1, 0, -1, 1'b0, -1, -1, -1, -1);
    chk("post_rst.pass_lit", pass, 1'b1);

    run_burst("midstart", 32'h0000_2000, 8'd31, 32'h1234_5678, 2, 1'b1, -1, 0, -1, 1'b0, -1, -1, 5, -1);

    for (int i = 0; i < 8; i++) begin
      rl = 8'($urandom_range(0, 40));
      bb = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, int'(rl))) : -1;
      run_burst("rnd", $urandom, rl, $urandom, int'($urandom_range(0, 4)), 1'b1,
                bb, int'($urandom_range(0, DW-1)), -1, 1'b0,
                ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, int'(rl))) : -1,
                -1, -1, -1);
    end

`ifdef AXIMM_RD_CHK_TIMEOUT_EN
    run_burst("wdog", 32'h1000_0000, 8'd127, 32'd0, 0, 1'b0, -1, 0, -1, 1'b0, -1, -1, -1, 20);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
